// File: rtl/vmem_sequencer.sv
// Vector load/store sequencer between issue, the 3x8-lane vector register file and data memory.
// Stores walk the register-file element counter; loads gather lanes and commit with one VRegWrite.
module vmem_sequencer #(
  parameter int unsigned DW   = 32,
  parameter int unsigned VMAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op_store,
  input  logic [1:0]          vreg,
  input  logic [31:0]         base_addr,
  input  logic [31:0]         vlen,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4:0]          rf_read_addr2,
  output logic [4:0]          rf_cnt,
  input  logic [DW-1:0]       rf_sw_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DW-1:0]       mem_rdata,
  output logic                vrf_write,
  output logic [4:0]          vrf_waddr,
  output logic [VMAX*DW-1:0]  vrf_wdata
);

  localparam int unsigned IW = $clog2(VMAX);
  localparam int unsigned NW = IW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSRd,
    StSWait,
    StSMem,
    StLReq,
    StLWait,
    StLWb,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      vreg_q, vreg_d;
  logic [31:0]     base_q, base_d;
  logic [NW-1:0]   n_q, n_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   lane_q [VMAX];
  logic [DW-1:0]   lane_d [VMAX];

  logic [NW-1:0]   n_clamp;
  logic            last_elem;
  logic            store_phase;

  // Lengths of VMAX or more saturate; below that only the low bits matter.
  assign n_clamp     = (vlen >= 32'(VMAX)) ? NW'(VMAX) : vlen[NW-1:0];
  assign last_elem   = ({1'b0, idx_q} == (n_q - NW'(1)));
  assign store_phase = (state_q == StSRd) || (state_q == StSWait) || (state_q == StSMem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vreg_q  <= '0;
      base_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      for (int k = 0; k < int'(VMAX); k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      vreg_q  <= vreg_d;
      base_q  <= base_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vreg_d  = vreg_q;
    base_d  = base_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          vreg_d = vreg;
          base_d = base_addr;
          n_d    = n_clamp;
          idx_d  = '0;
          for (int k = 0; k < int'(VMAX); k++) begin
            lane_d[k] = '0;
          end
          if (vreg == 2'd3) begin
            state_d = StDone;
          end else if (n_clamp == '0) begin
            state_d = StDone;
          end else if (op_store) begin
            state_d = StSRd;
          end else begin
            state_d = StLReq;
          end
        end
      end
      StSRd: begin
        state_d = StSWait;
      end
      StSWait: begin
        // Register file output is valid one cycle after rf_cnt was presented.
        wdata_d = rf_sw_data;
        state_d = StSMem;
      end
      StSMem: begin
        if (mem_ready) begin
          idx_d   = idx_q + IW'(1);
          state_d = last_elem ? StDone : StSRd;
        end
      end
      StLReq: begin
        if (mem_ready) begin
          state_d = StLWait;
        end
      end
      StLWait: begin
        if (mem_rvalid) begin
          lane_d[idx_q] = mem_rdata;
          if (last_elem) begin
            state_d = StLWb;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StLReq;
          end
        end
      end
      StLWb: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q != StIdle) && (state_q != StDone);
    done          = (state_q == StDone);
    err           = (state_q == StDone) && (vreg_q == 2'd3);
    rf_read_addr2 = '0;
    rf_cnt        = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    vrf_write     = 1'b0;
    vrf_waddr     = '0;
    vrf_wdata     = '0;

    if (store_phase) begin
      rf_read_addr2 = 5'd8 + {vreg_q, 3'b000};
      rf_cnt        = 5'(idx_q) + 5'd1;
    end

    if ((state_q == StSMem) || (state_q == StLReq)) begin
      mem_req  = 1'b1;
      mem_we   = (state_q == StSMem);
      mem_addr = base_q + (32'(idx_q) << 2);
    end

    if (state_q == StSMem) begin
      mem_wdata = wdata_q;
    end

    if (state_q == StLWb) begin
      vrf_write = 1'b1;
      vrf_waddr = {3'b000, vreg_q};
      for (int k = 0; k < int'(VMAX); k++) begin
        vrf_wdata[k*DW +: DW] = lane_q[k];
      end
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Directed bench for vmem_sequencer: register-file and memory responders plus hand-computed checks.
module tb_vmem_sequencer;

  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            op_store = 1'b0;
  logic [1:0]      vreg = '0;
  logic [31:0]     base_addr = '0;
  logic [31:0]     vlen = '0;
  logic            busy, done, err;
  logic [4:0]      rf_read_addr2, rf_cnt;
  logic [DW-1:0]   rf_sw_data = '0;
  logic            mem_req, mem_we;
  logic [31:0]     mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            vrf_write;
  logic [4:0]      vrf_waddr;
  logic [8*DW-1:0] vrf_wdata;

  always #5 clk = ~clk;

  vmem_sequencer #(.DW(DW), .VMAX(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .op_store      (op_store),
    .vreg          (vreg),
    .base_addr     (base_addr),
    .vlen          (vlen),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rf_read_addr2 (rf_read_addr2),
    .rf_cnt        (rf_cnt),
    .rf_sw_data    (rf_sw_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .vrf_write     (vrf_write),
    .vrf_waddr     (vrf_waddr),
    .vrf_wdata     (vrf_wdata)
  );

  // Register file: registered read of gpr[read_addr2 + cnt - 1].
  logic [DW-1:0] gpr [32];
  always @(posedge clk) begin
    if (rf_cnt != 5'd0) rf_sw_data <= gpr[int'(rf_read_addr2) + int'(rf_cnt) - 1];
  end

  // Memory responder knobs (written by the stimulus process only).
  int ready_delay = 0;
  int rv_delay    = 0;
  bit inject_rv   = 1'b0;

  // Responder/monitor state (written by the monitor only).
  int            req_age = 0, rv_wait = 0;
  bit            rv_pending = 1'b0;
  logic [31:0]   rv_addr = '0, h_addr = '0;
  logic          h_we = 1'b0;
  logic [DW-1:0] h_data = '0;
  int            hold_seen = 0, hold_err = 0, rv_count = 0, vrf_n = 0, req_cycles = 0;
  logic [4:0]    vrf_waddr_seen = '0;
  logic [8*DW-1:0] vrf_wdata_seen = '0;
  logic [31:0]   log_addr [$];
  logic [31:0]   log_data [$];
  bit            log_we [$];
  logic [4:0]    log_cnt [$];
  logic [4:0]    log_ra2 [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      rv_pending = 1'b0;
      req_age    = 0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (rv_pending) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_addr;
          rv_pending = 1'b0;
          rv_count++;
        end else begin
          rv_wait--;
        end
      end else if (inject_rv && mem_req && !mem_we) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (mem_req) begin
        req_cycles++;
        if (req_age == 0) begin
          h_addr = mem_addr;
          h_we   = mem_we;
          h_data = mem_wdata;
        end else begin
          hold_seen++;
          if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_data) hold_err++;
        end
        if (req_age == ready_delay) begin
          mem_ready = 1'b1;
          req_age   = 0;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
          log_we.push_back(mem_we);
          log_cnt.push_back(rf_cnt);
          log_ra2.push_back(rf_read_addr2);
          if (!mem_we) begin
            rv_pending = 1'b1;
            rv_wait    = rv_delay;
            rv_addr    = mem_addr;
          end
        end else begin
          mem_ready = 1'b0;
          req_age++;
        end
      end else begin
        mem_ready = 1'b0;
        req_age   = 0;
      end
      if (vrf_write) begin
        vrf_n++;
        vrf_waddr_seen = vrf_waddr;
        vrf_wdata_seen = vrf_wdata;
      end
    end
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [8*DW-1:0] got,
                          input logic [8*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*DW-1:0] lanes(input logic [31:0] base, input int n);
    logic [8*DW-1:0] v = '0;
    for (int i = 0; i < n; i++) v[i*DW +: DW] = base + 32'(4 * i);
    return v;
  endfunction

  int r_done_cyc, r_log0, r_vrf0, r_req0, r_hold0, r_holderr0;
  bit r_err, r_busy1;

  // Issues one operation; cycle 1 is the first cycle after the accepting edge.
  task automatic run_op(input bit st, input logic [1:0] vr, input logic [31:0] base,
                        input logic [31:0] vl, input int poke);
    int cyc;
    r_log0     = log_addr.size();
    r_vrf0     = vrf_n;
    r_req0     = req_cycles;
    r_hold0    = hold_seen;
    r_holderr0 = hold_err;
    @(posedge clk); #1;
    start = 1'b1; op_store = st; vreg = vr; base_addr = base; vlen = vl;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; r_done_cyc = -1; r_err = 1'b0; r_busy1 = busy;
    while (cyc <= 300) begin
      if (done) begin
        r_done_cyc = cyc;
        r_err      = err;
        break;
      end
      if (cyc == poke) begin
        start = 1'b1; op_store = ~st; vreg = 2'd0; base_addr = 32'h900; vlen = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("done_pulse", done, 1'b0);
  endtask

  task automatic check_xfer(input string tag, input int k, input logic [31:0] addr, input bit we,
                            input logic [31:0] data, input logic [4:0] cnt, input logic [4:0] ra2);
    int j = r_log0 + k;
    check_eq($sformatf("%s_addr%0d", tag, k), log_addr[j], addr);
    check_eq($sformatf("%s_we%0d", tag, k), log_we[j], we);
    check_eq($sformatf("%s_data%0d", tag, k), log_data[j], data);
    check_eq($sformatf("%s_cnt%0d", tag, k), log_cnt[j], cnt);
    check_eq($sformatf("%s_ra2_%0d", tag, k), log_ra2[j], ra2);
  endtask

  task automatic check_idle_outs(input string tag);
    check_eq(tag, {busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, rf_cnt,
                   rf_read_addr2, vrf_write, vrf_waddr}, '0);
    check_eq({tag, "_wdata"}, vrf_wdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rv0, vrf0;
    for (int k = 0; k < 32; k++) gpr[k] = 32'hC000_0000 + 32'(k);
    gpr[16] = 32'hA0; gpr[17] = 32'hA1; gpr[18] = 32'hA2;
    gpr[8]  = 32'h11; gpr[9]  = 32'h22;

    repeat (2) @(posedge clk);
    #1;
    check_idle_outs("reset_outs");
    rst_n = 1'b1;

    // Store v1, three elements.
    run_op(1'b1, 2'd1, 32'h100, 32'd3, -1);
    check_eq("st_done_cyc", r_done_cyc, 10);
    check_eq("st_err", r_err, 1'b0);
    check_eq("st_busy1", r_busy1, 1'b1);
    check_eq("st_nxfer", log_addr.size() - r_log0, 3);
    check_xfer("st", 0, 32'h100, 1'b1, 32'hA0, 5'd1, 5'd16);
    check_xfer("st", 1, 32'h104, 1'b1, 32'hA1, 5'd2, 5'd16);
    check_xfer("st", 2, 32'h108, 1'b1, 32'hA2, 5'd3, 5'd16);
    check_eq("st_no_vrf", vrf_n - r_vrf0, 0);

    // Full-length load into v2.
    run_op(1'b0, 2'd2, 32'h200, 32'd8, -1);
    check_eq("ld_done_cyc", r_done_cyc, 18);
    check_eq("ld_nxfer", log_addr.size() - r_log0, 8);
    check_xfer("ld", 0, 32'h200, 1'b0, 32'h0, 5'd0, 5'd0);
    check_xfer("ld", 7, 32'h21C, 1'b0, 32'h0, 5'd0, 5'd0);
    check_eq("ld_nvrf", vrf_n - r_vrf0, 1);
    check_eq("ld_waddr", vrf_waddr_seen, 5'd2);
    check_eq("ld_wdata", vrf_wdata_seen, lanes(32'h200, 8));

    // vlen = 0.
    run_op(1'b1, 2'd0, 32'h100, 32'd0, -1);
    check_eq("z_done_cyc", r_done_cyc, 1);
    check_eq("z_err", r_err, 1'b0);
    check_eq("z_busy1", r_busy1, 1'b0);
    check_eq("z_noreq", req_cycles - r_req0, 0);
    check_eq("z_no_vrf", vrf_n - r_vrf0, 0);

    // vreg = 3 error path.
    run_op(1'b0, 2'd3, 32'h100, 32'd4, -1);
    check_eq("e_done_cyc", r_done_cyc, 1);
    check_eq("e_err", r_err, 1'b1);
    check_eq("e_noreq", req_cycles - r_req0, 0);
    check_eq("e_no_vrf", vrf_n - r_vrf0, 0);

    // vlen = 12 clamps to 8.
    run_op(1'b0, 2'd0, 32'h40, 32'd12, -1);
    check_eq("c_done_cyc", r_done_cyc, 18);
    check_eq("c_nxfer", log_addr.size() - r_log0, 8);
    check_eq("c_waddr", vrf_waddr_seen, 5'd0);
    check_eq("c_wdata", vrf_wdata_seen, lanes(32'h40, 8));

    // Address wrap.
    run_op(1'b1, 2'd0, 32'hFFFF_FFFC, 32'd2, -1);
    check_eq("w_done_cyc", r_done_cyc, 7);
    check_eq("w_nxfer", log_addr.size() - r_log0, 2);
    check_xfer("w", 0, 32'hFFFF_FFFC, 1'b1, 32'h11, 5'd1, 5'd8);
    check_xfer("w", 1, 32'h0000_0000, 1'b1, 32'h22, 5'd2, 5'd8);

    // Store with four wait cycles per request.
    ready_delay = 4;
    run_op(1'b1, 2'd1, 32'h100, 32'd3, -1);
    check_eq("bs_done_cyc", r_done_cyc, 22);
    check_eq("bs_nxfer", log_addr.size() - r_log0, 3);
    check_xfer("bs", 0, 32'h100, 1'b1, 32'hA0, 5'd1, 5'd16);
    check_xfer("bs", 1, 32'h104, 1'b1, 32'hA1, 5'd2, 5'd16);
    check_xfer("bs", 2, 32'h108, 1'b1, 32'hA2, 5'd3, 5'd16);
    check_eq("bs_hold_seen", (hold_seen - r_hold0) > 0, 1'b1);
    check_eq("bs_hold_err", hold_err - r_holderr0, 0);

    // Load with request stalls and late read data.
    ready_delay = 2;
    rv_delay    = 3;
    run_op(1'b0, 2'd1, 32'h500, 32'd3, -1);
    check_eq("bl_done_cyc", r_done_cyc, 23);
    check_eq("bl_nxfer", log_addr.size() - r_log0, 3);
    check_eq("bl_hold_err", hold_err - r_holderr0, 0);
    check_eq("bl_waddr", vrf_waddr_seen, 5'd1);
    check_eq("bl_wdata", vrf_wdata_seen, lanes(32'h500, 3));
    ready_delay = 0;
    rv_delay    = 0;

    // start while busy and rvalid in L_REQ are both ignored.
    inject_rv = 1'b1;
    run_op(1'b0, 2'd1, 32'h600, 32'd2, 2);
    inject_rv = 1'b0;
    check_eq("p_done_cyc", r_done_cyc, 6);
    check_eq("p_nxfer", log_addr.size() - r_log0, 2);
    check_eq("p_wdata", vrf_wdata_seen, lanes(32'h600, 2));
    repeat (3) @(posedge clk);
    #1;
    check_eq("p_idle_busy", busy, 1'b0);
    check_eq("p_noreq_after", req_cycles - r_req0, 2);

    // Reset in the middle of a load.
    rv0  = rv_count;
    vrf0 = vrf_n;
    @(posedge clk); #1;
    start = 1'b1; op_store = 1'b0; vreg = 2'd2; base_addr = 32'h200; vlen = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((rv_count - rv0) < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("r_lanes_before", rv_count - rv0, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outs("r_outs");
    rst_n = 1'b1;
    check_eq("r_no_vrf", vrf_n - vrf0, 0);
    run_op(1'b0, 2'd2, 32'h300, 32'd2, -1);
    check_eq("r2_done_cyc", r_done_cyc, 6);
    check_eq("r2_nvrf", vrf_n - vrf0, 1);
    check_eq("r2_wdata", vrf_wdata_seen, lanes(32'h300, 2));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vmem_sequencer.md
# vmem_sequencer

Sequences vector load (VLW) and vector store (VSW) transfers between the data memory port and the 3×8-lane vector register file.
- Stores: steps the register file's element counter `cnt`, one element per memory write.
- Loads: gathers up to 8 memory words into a lane buffer, then commits them with a single VRegWrite pulse.
- Sits between the decode/issue stage, the register file and the data-memory interface; stalls issue via `busy`.

## Interface
- DW, 32, data width of memory words and vector elements
- VMAX, 8, lanes per vector register (fixed at 8)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  start request; accepted only in IDLE, ignored otherwise
- op_store  in  1  1 = vector store, 0 = vector load; sampled with start
- vreg  in  2  vector register index 0..2; sampled with start
- base_addr  in  32  byte address of element 0; sampled with start
- vlen  in  32  vector length (gpr[7]); sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done when vreg==3
- rf_read_addr2  out  5  register-file read_addr2; 8+8*vreg during store, else 0
- rf_cnt  out  5  register-file cnt; element index+1 during store, else 0
- rf_sw_data  in  DW  register-file read_data2, registered, 1-cycle latency
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  byte address
- mem_wdata  out  DW  write data
- mem_ready  in  1  request accepted when mem_req && mem_ready
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- vrf_write  out  1  VRegWrite pulse
- vrf_waddr  out  5  vector register index for VRegWrite
- vrf_wdata  out  8*DW  lane i at bits [DW*i+DW-1 : DW*i]

## Operation
- On accept, latch op, vreg, base and n = min(vlen, 8).
- Element index i (3 bits) starts at 0.
- Address is base + 4*i, modulo 2^32 (wrap allowed).
- States:
  - IDLE: on accept, go to DONE (with err) if vreg==3; go to DONE if n==0; else go to S_RD (store) or L_REQ (load).
  - S_RD: rf_cnt = i+1 → S_WAIT.
  - S_WAIT: register file captures gpr[8+8*vreg+i]; rf_cnt held → S_MEM.
  - S_MEM: mem_req=1, mem_we=1, mem_wdata = rf_sw_data captured on S_WAIT exit, held stable until ready.
    - On accept: i++; if i==n-1 → DONE, else → S_RD.
  - L_REQ: mem_req=1, mem_we=0; hold until ready → L_WAIT.
  - L_WAIT: on mem_rvalid, buffer[i] = mem_rdata.
    - If i==n-1 → L_WB, else i++ → L_REQ.
  - L_WB: vrf_write=1 for one cycle, vrf_waddr=vreg; lanes ≥ n driven 0 → DONE.
  - DONE: done=1 (err=1 if vreg==3) → IDLE.
- mem_rvalid outside L_WAIT is ignored.
- vlen > 8 is clamped to 8. Only the low 4 bits are compared after the vlen ≥ 8 check.
- vrf_write never asserts for stores, for n==0, or on the err path.
- The lane buffer is cleared at each accept.

## Timing
- Reset: synchronous. Any state → IDLE next edge, i=0, buffer=0.
  - All outputs 0: busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, rf_cnt, rf_read_addr2, vrf_write, vrf_waddr, vrf_wdata.
  - An in-flight memory request is abandoned; no done is issued.
- Accept at edge E: the state is non-IDLE from E+1.
- Store, mem_ready tied 1: 3 cycles per element; done at cycle 3n+1 after accept.
- Load, ready=1 and rvalid the cycle after the request: 2 cycles per element, +1 for L_WB; done at 2n+2.
- n==0 or err: done at the first cycle after accept; no memory or VRF activity.
- mem_addr, mem_we and mem_wdata are stable while mem_req && !mem_ready.
- start pulses during busy or DONE are dropped.

## Test plan
- Store: vreg=1, vlen=3, base=0x100, register file v1 = {0xA0, 0xA1, 0xA2}, ready=1 → writes (0x100,0xA0), (0x104,0xA1), (0x108,0xA2); rf_cnt sequence 1,2,3; rf_read_addr2=16; done at cycle 10.
- Load: vreg=2, vlen=8, base=0x200, rdata = address → single vrf_write with waddr=2, lane i = 0x200+4i; done at cycle 18.
- Backpressure: store with mem_ready low for 4 cycles per request and rvalid delayed 3 cycles on loads → request fields held stable, ordering unchanged, no lost elements.
- Boundaries:
  - vlen=0 → done at cycle 1, no mem_req.
  - vlen=12 → exactly 8 transfers.
  - vreg=3 → done+err at cycle 1.
  - base=0xFFFFFFFC, n=2 → second address 0x00000000.
- Reset asserted in the middle of a load after 3 lanes → all outputs 0 next cycle, no vrf_write; a fresh load of vlen=2 then returns lanes 2..7 = 0.
- start pulsed while busy, and mem_rvalid pulsed in L_REQ → both ignored; only the original transfer completes.
